// File: rtl/codec_hdr_pkg.sv
// Shared definitions for the Annex-B front end: FSM states, special stream
// bytes, well-known NAL unit types and the byte-to-buffer bit ordering.
package codec_hdr_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    HEADER,
    PAYLOAD,
    HOLD
  } rbsp_state_t;

  localparam logic [7:0] START_CODE_BYTE = 8'h01;
  localparam logic [7:0] EPB_BYTE        = 8'h03;

  localparam logic [4:0] NAL_IDR = 5'd5;
  localparam logic [4:0] NAL_SPS = 5'd7;
  localparam logic [4:0] NAL_PPS = 5'd8;

  // Bit 7 of a stream byte lands at the lowest buffer index of its slot.
  function automatic logic [7:0] msb_first(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[7-i] = b[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rbsp_extractor.sv
// Annex-B start-code search, NAL header capture and emulation-prevention
// removal. The RBSP payload is packed MSB-first into a flat buffer that is
// held with a valid/ack handshake until the downstream reader releases it.
module rbsp_extractor
  import codec_hdr_pkg::*;
#(
  parameter int BITSTREAM_WIDTH = 3072
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  input  logic [7:0]                 s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [BITSTREAM_WIDTH-1:0] bitstream,
  output logic [11:0]                rbsp_bytes,
  output logic [1:0]                 nal_ref_idc,
  output logic [4:0]                 nal_unit_type,
  output logic                       forbidden_err,
  output logic                       overflow,
  output logic [7:0]                 epb_count,
  output logic                       nal_valid,
  input  logic                       nal_ack
);

  localparam int          MAX_BYTES   = BITSTREAM_WIDTH / 8;
  localparam int          IDX_W       = $clog2(BITSTREAM_WIDTH);
  localparam logic [12:0] MAX_BYTES_W = 13'(MAX_BYTES);

  rbsp_state_t      state, state_nxt;
  logic [11:0]      zero_cnt, zero_nxt;
  logic [11:0]      bytes_nxt;
  logic             ovf_nxt;
  logic             end_sc, end_sc_nxt;
  logic             epb_inc, wr_en, hdr_cap, clear_nal;
  logic             accept;
  logic [12:0]      sum_w, epb_sum;
  logic [IDX_W-1:0] bit_base;

  assign s_ready   = (state != HOLD);
  assign nal_valid = (state == HOLD);
  assign accept    = s_valid && s_ready;

  // Pending zeros are materialised implicitly: the buffer is pre-cleared, so
  // a write simply lands after them.
  assign sum_w    = {1'b0, rbsp_bytes} + {1'b0, zero_cnt};
  assign epb_sum  = {1'b0, rbsp_bytes} + 13'd2;
  assign bit_base = IDX_W'({sum_w, 3'b000});

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  // Next-state logic plus per-byte decisions: zero tracking, EPB removal,
  // buffer writes with overflow saturation, and the ack-driven release.
  always_comb begin
    state_nxt  = state;
    zero_nxt   = zero_cnt;
    bytes_nxt  = rbsp_bytes;
    ovf_nxt    = overflow;
    end_sc_nxt = end_sc;
    epb_inc    = 1'b0;
    wr_en      = 1'b0;
    hdr_cap    = 1'b0;
    clear_nal  = 1'b0;
    unique case (state)
      SEARCH: begin
        if (accept) begin
          if (s_last) begin
            zero_nxt = '0;
          end else if (s_data == 8'h00) begin
            zero_nxt = zero_cnt + 12'd1;
          end else if (s_data == START_CODE_BYTE && zero_cnt >= 12'd2) begin
            state_nxt = HEADER;
            zero_nxt  = '0;
          end else begin
            zero_nxt = '0;
          end
        end
      end
      HEADER: begin
        if (accept) begin
          hdr_cap  = 1'b1;
          zero_nxt = '0;
          if (s_last) begin
            state_nxt  = HOLD;
            end_sc_nxt = 1'b0;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          if (s_data == 8'h00) begin
            zero_nxt = zero_cnt + 12'd1;
          end else if (s_data == START_CODE_BYTE && zero_cnt >= 12'd2) begin
            zero_nxt   = '0;
            state_nxt  = HOLD;
            end_sc_nxt = 1'b1;
          end else if (s_data == EPB_BYTE && zero_cnt == 12'd2) begin
            epb_inc  = 1'b1;
            zero_nxt = '0;
            if (epb_sum > MAX_BYTES_W) begin
              ovf_nxt   = 1'b1;
              bytes_nxt = MAX_BYTES_W[11:0];
            end else begin
              bytes_nxt = epb_sum[11:0];
            end
          end else begin
            zero_nxt = '0;
            if (sum_w >= MAX_BYTES_W) begin
              ovf_nxt   = 1'b1;
              bytes_nxt = MAX_BYTES_W[11:0];
            end else begin
              wr_en     = 1'b1;
              bytes_nxt = sum_w[11:0] + 12'd1;
            end
          end
          if (s_last) begin
            state_nxt  = HOLD;
            end_sc_nxt = 1'b0;
            zero_nxt   = '0;
          end
        end
      end
      HOLD: begin
        if (nal_ack) begin
          clear_nal = 1'b1;
          bytes_nxt = '0;
          ovf_nxt   = 1'b0;
          state_nxt = end_sc ? HEADER : SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Datapath registers: counters, captured header fields and the RBSP buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_cnt      <= '0;
      rbsp_bytes    <= '0;
      overflow      <= 1'b0;
      end_sc        <= 1'b0;
      epb_count     <= '0;
      forbidden_err <= 1'b0;
      nal_ref_idc   <= '0;
      nal_unit_type <= '0;
      bitstream     <= '0;
    end else begin
      zero_cnt   <= zero_nxt;
      rbsp_bytes <= bytes_nxt;
      overflow   <= ovf_nxt;
      end_sc     <= end_sc_nxt;
      if (clear_nal) begin
        epb_count     <= '0;
        forbidden_err <= 1'b0;
        bitstream     <= '0;
      end else begin
        if (epb_inc && epb_count != 8'hFF) epb_count <= epb_count + 8'd1;
        if (hdr_cap) begin
          forbidden_err <= s_data[7];
          nal_ref_idc   <= s_data[6:5];
          nal_unit_type <= s_data[4:0];
        end
        if (wr_en) bitstream[bit_base +: 8] <= msb_first(s_data);
      end
    end
  end

endmodule

// File: tb/tb_rbsp_extractor.sv
// Scoreboard bench: NALs are generated as RBSP payloads, emulation-prevention
// encoded into an Annex-B stream, and the expected decode is queued; a monitor
// compares each presented NAL, then acknowledges it after a random delay.
module tb_rbsp_extractor;

  localparam int W  = 3072;
  localparam int WS = 64;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       last;
  } item_t;
  typedef struct {
    logic [W-1:0] bits;
    int           nbytes;
    int           epb;
    logic [7:0]   hdr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic s_valid, s_last, s_ready, nal_valid, nal_ack;
  logic [7:0] s_data, epb_count;
  logic [W-1:0] bitstream;
  logic [11:0] rbsp_bytes;
  logic [1:0] nal_ref_idc;
  logic [4:0] nal_unit_type;
  logic forbidden_err, overflow;

  logic s2_valid, s2_last, s2_ready, nal2_valid, nal2_ack;
  logic [7:0] s2_data, epb2_count;
  logic [WS-1:0] bitstream2;
  logic [11:0] rbsp2_bytes;
  logic [1:0] nal2_ref_idc;
  logic [4:0] nal2_unit_type;
  logic forbidden2_err, overflow2;

  rbsp_extractor #(.BITSTREAM_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .bitstream(bitstream), .rbsp_bytes(rbsp_bytes),
    .nal_ref_idc(nal_ref_idc), .nal_unit_type(nal_unit_type),
    .forbidden_err(forbidden_err), .overflow(overflow), .epb_count(epb_count),
    .nal_valid(nal_valid), .nal_ack(nal_ack)
  );

  rbsp_extractor #(.BITSTREAM_WIDTH(WS)) dut_small (
    .clk(clk), .reset(reset), .s_valid(s2_valid), .s_data(s2_data), .s_last(s2_last),
    .s_ready(s2_ready), .bitstream(bitstream2), .rbsp_bytes(rbsp2_bytes),
    .nal_ref_idc(nal2_ref_idc), .nal_unit_type(nal2_unit_type),
    .forbidden_err(forbidden2_err), .overflow(overflow2), .epb_count(epb2_count),
    .nal_valid(nal2_valid), .nal_ack(nal2_ack)
  );

  int total = 0;
  int bad = 0;
  item_t stream_q[$];
  exp_t exp_q[$];
  bit mon_en = 1'b0;
  bit after_stream = 1'b1;

  task automatic checkOutput(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic checkBits(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    int k;
    total++;
    if (got !== want) begin
      bad++;
      k = 0;
      while (k < W / 8 - 1 && got[8*k +: 8] === want[8*k +: 8]) k++;
      $display("[TB] FAIL %s: buffer byte %0d got %h expected %h", nm, k, got[8*k +: 8], want[8*k +: 8]);
    end
  endtask

  // Stream byte k, bit i goes to buffer index 8k+7-i.
  function automatic logic [W-1:0] pack(input bq_t b);
    logic [W-1:0] v = '0;
    for (int k = 0; k < b.size() && k < W / 8; k++)
      for (int i = 0; i < 8; i++)
        v[8*k + 7 - i] = b[k][i];
    return v;
  endfunction

  function automatic bq_t randPayload(input int len);
    bq_t p;
    for (int i = 0; i < len; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    p.push_back(8'h00);
        2:       p.push_back(8'h01);
        3:       p.push_back(8'h03);
        default: p.push_back(8'($urandom_range(0, 255)));
      endcase
    end
    if (len > 0 && p[len-1] == 8'h00) p[len-1] = 8'($urandom_range(1, 255));
    return p;
  endfunction

  // Encode one NAL into the stream (start code, header, EPB-protected payload)
  // and queue what a correct extractor must present for it.
  task automatic applyStimulus(input logic [7:0] hdr, input bq_t pay, input int nz,
                               input bit by_last, input bit trail);
    exp_t e;
    int zeros = 0;
    int epb = 0;
    item_t it;
    it.last = 1'b0;
    if (after_stream) begin
      repeat ($urandom_range(0, 3)) begin
        it.d = 8'($urandom_range(4, 255));
        stream_q.push_back(it);
      end
    end
    it.d = 8'h00;
    repeat (nz) stream_q.push_back(it);
    it.d = 8'h01; stream_q.push_back(it);
    it.d = hdr;   stream_q.push_back(it);
    foreach (pay[i]) begin
      if (zeros >= 2 && pay[i] <= 8'h03) begin
        it.d = 8'h03; stream_q.push_back(it);
        epb++;
        zeros = 0;
      end
      it.d = pay[i]; stream_q.push_back(it);
      zeros = (pay[i] == 8'h00) ? zeros + 1 : 0;
    end
    if (by_last) begin
      if (trail) begin
        it.d = 8'h00;
        repeat ($urandom_range(1, 2)) stream_q.push_back(it);
      end
      stream_q[stream_q.size()-1].last = 1'b1;
    end
    after_stream = by_last;
    e.bits = pack(pay);
    e.nbytes = pay.size();
    e.epb = epb;
    e.hdr = hdr;
    exp_q.push_back(e);
  endtask

  task automatic sendMain(input logic [7:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic sendSmall(input logic [7:0] d, input logic l);
    s2_valid = 1'b1; s2_data = d; s2_last = l;
    @(posedge clk); #1;
    s2_valid = 1'b0; s2_last = 1'b0;
  endtask

  // Monitor: compare each presented NAL against the queue head, check it is
  // held stable, acknowledge it, and check that the release clears it.
  initial begin : monitor
    exp_t e;
    logic [W-1:0] snap;
    int d;
    nal_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checkOutput("s_ready", s_ready, !nal_valid);
        if (nal_valid) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL unexpected_nal: got type %0d expected none", nal_unit_type);
          end else begin
            e = exp_q.pop_front();
            checkOutput("rbsp_bytes", rbsp_bytes, e.nbytes);
            checkOutput("epb_count", epb_count, e.epb);
            checkOutput("nal_ref_idc", nal_ref_idc, e.hdr[6:5]);
            checkOutput("nal_unit_type", nal_unit_type, e.hdr[4:0]);
            checkOutput("forbidden_err", forbidden_err, e.hdr[7]);
            checkOutput("overflow", overflow, 0);
            checkBits("bitstream", bitstream, e.bits);
          end
          snap = bitstream;
          d = $urandom_range(0, 10);
          repeat (d) begin
            @(negedge clk);
            checkOutput("hold_valid", nal_valid, 1);
            checkOutput("hold_ready", s_ready, 0);
            checkBits("hold_stable", bitstream, snap);
          end
          nal_ack = 1'b1;
          @(negedge clk);
          nal_ack = 1'b0;
          checkOutput("ack_valid", nal_valid, 0);
          checkOutput("ack_bytes", rbsp_bytes, 0);
          checkOutput("ack_epb", epb_count, 0);
          checkOutput("ack_forbidden", forbidden_err, 0);
          checkBits("ack_bitstream", bitstream, '0);
        end else if ($urandom_range(0, 7) == 0) begin
          nal_ack = 1'b1;
          @(negedge clk);
          nal_ack = 1'b0;
        end
      end
    end
  end

  initial begin : main
    bq_t p;
    bq_t ovf;
    bit acc;
    int cyc;
    bit last_nal;
    reset = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s2_valid = 1'b0; s2_data = '0; s2_last = 1'b0; nal2_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", nal_valid, 0);
    checkOutput("rst_bytes", rbsp_bytes, 0);
    checkOutput("rst_ready", s_ready, 1);
    checkOutput("rst_epb", epb_count, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkBits("rst_bitstream", bitstream, '0);
    reset = 1'b0;

    // Overflow on the 8-byte instance: ten 0x55 bytes into an 8-byte buffer.
    sendSmall(8'h00, 1'b0); sendSmall(8'h00, 1'b0); sendSmall(8'h01, 1'b0);
    sendSmall(8'h06, 1'b0);
    for (int i = 0; i < 10; i++) sendSmall(8'h55, i == 9);
    for (int i = 0; i < 8; i++) ovf.push_back(8'h55);
    checkOutput("ovf_valid", nal2_valid, 1);
    checkOutput("ovf_flag", overflow2, 1);
    checkOutput("ovf_bytes", rbsp2_bytes, 8);
    checkOutput("ovf_type", nal2_unit_type, 6);
    checkBits("ovf_bitstream", W'(bitstream2), pack(ovf));
    checkOutput("ovf_pattern_lo", bitstream2[31:0], 32'hAAAA_AAAA);
    nal2_ack = 1'b1;
    @(posedge clk); #1;
    nal2_ack = 1'b0;
    checkOutput("ovf_ack_valid", nal2_valid, 0);
    checkOutput("ovf_ack_flag", overflow2, 0);
    checkOutput("ovf_ack_bytes", rbsp2_bytes, 0);

    // Reset in the middle of a NAL discards it.
    sendMain(8'h00, 1'b0); sendMain(8'h00, 1'b0); sendMain(8'h01, 1'b0);
    sendMain(8'h65, 1'b0);
    sendMain(8'h11, 1'b0); sendMain(8'h22, 1'b0); sendMain(8'h33, 1'b0);
    checkOutput("pre_rst_bytes", rbsp_bytes, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_valid", nal_valid, 0);
    checkOutput("midrst_bytes", rbsp_bytes, 0);
    checkBits("midrst_bitstream", bitstream, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed NALs followed by randomized ones.
    mon_en = 1'b1;
    p = {8'h42, 8'h00, 8'h1F};
    applyStimulus(8'h67, p, 3, 1'b0, 1'b0);
    p = {8'hAA, 8'h00, 8'h00, 8'h01, 8'hBB};
    applyStimulus(8'h65, p, 2, 1'b1, 1'b0);
    p = {8'h01, 8'h02};
    applyStimulus(8'hE7, p, 2, 1'b0, 1'b0);
    p = randPayload(12);
    applyStimulus(8'h68, p, 3, 1'b0, 1'b0);
    for (int n = 0; n < 30; n++) begin
      last_nal = (n == 29);
      p = randPayload($urandom_range(0, 24));
      applyStimulus(8'($urandom_range(0, 255)), p, $urandom_range(2, 4),
                    last_nal || ($urandom_range(0, 2) == 0), $urandom_range(0, 3) == 0);
    end

    cyc = 0;
    while (stream_q.size() > 0 && cyc < 40000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data = stream_q[0].d;
      s_last = stream_q[0].last;
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) void'(stream_q.pop_front());
    end
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("stream_drained", stream_q.size(), 0);

    cyc = 0;
    while ((exp_q.size() > 0 || nal_valid) && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    checkOutput("nals_outstanding", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
